uart8_transmitter: RTL
======================

Name: uart8_transmitter

Overview:
- 8N1 UART transmitter; the transmit-side counterpart of the team's 8-bit UART receiver.
- Runs on the same oversampled clock: each serial bit lasts OVERSAMPLE clock cycles. Receiver and transmitter therefore share one clock and one baud setting.
- Sits between the matrix-result logic (byte source) and the board TX pin.
- Accepts one byte per start handshake and shifts it out LSB-first, framed by a start bit and stop bit(s).

Parameters:
- OVERSAMPLE, 16: clock cycles per serial bit. Must be ≥2; 16 matches the receiver.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  oversampled baud clock (OVERSAMPLE × baud rate).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low aborts any frame and holds the block idle.
- start  input  1  request to send `in`; sampled only in IDLE.
- in  input  8  byte to transmit; latched on the accepted start.
- out  output  1  serial TX line; idle high.
- done  output  1  one-cycle pulse when a frame completes.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst_n low, asynchronous): out=1, busy=0, done=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- All outputs are registered. out never glitches and is driven high in every non-frame state.
- States:
  - IDLE: out=1, busy=0. If en=1 and start=1: latch in into the shift register, clear counters, set busy=1, go to START_BIT.
  - START_BIT: out=0 for OVERSAMPLE cycles, then go to DATA_BITS.
  - DATA_BITS: out=shift[bitIdx] for OVERSAMPLE cycles per bit, bitIdx 0..7, LSB first. After bit 7 go to STOP_BIT (or PARITY_BIT when the optional feature is compiled in).
  - STOP_BIT: out=1 for STOP_BITS×OVERSAMPLE cycles. On the final cycle edge: state=IDLE, busy=0, done=1.
- Latency: start is accepted at edge N; out falls at edge N (visible in cycle N+1).
- Total frame = (1+8+STOP_BITS)×OVERSAMPLE cycles; 160 at defaults. The done pulse occurs on the cycle the frame ends.
- done is high for exactly one cycle and is cleared unconditionally on the next edge.
- Back-to-back: a start sampled in the cycle where done=1 (state already IDLE) is accepted, giving zero idle gap between frames.
- start while busy=1 is ignored. in is not re-sampled mid-frame; changing in mid-frame has no effect.
- en low in any state (synchronous): on the next edge state=IDLE, out=1, busy=0, counters cleared, no done pulse. The aborted byte is discarded. en low with start high in IDLE → no start.
- rst_n asserted mid-frame: immediate idle-high line; the frame is lost.
- Counter width: $clog2(OVERSAMPLE×STOP_BITS) bits. It counts 0..limit−1 with no wrap beyond the limit.
- Unreachable state encodings return to IDLE with out=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY_BIT state is inserted between DATA_BITS and STOP_BIT. It drives even parity (XOR of the latched byte) for OVERSAMPLE cycles. Frame length becomes (10+STOP_BITS)×OVERSAMPLE.
- Undefined: no parity state or logic exists; pure 8N1 framing.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT;
  - default OVERSAMPLE=16;
  - DATA_BITS_N=8.
- The receiver and transmitter both use uart_pkg.
- One natural sub-module: uart_bit_timer, a parameterised cycle counter with clear input and a terminal-count pulse output. It can be reused by the receiver rework.
- Shifting and the FSM stay in the top module.

Test Plan:
- Reset then idle: rst_n low for 3 cycles → out=1, busy=0, done=0. With start held low for 200 cycles, out stays 1.
- Send 0xA5 at defaults: pulse start for 1 cycle → bit sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clocks. busy high for 160 cycles; done pulses once, exactly at cycle 160.
- Back-to-back: send 0x00, then assert start with in=0xFF in the done cycle → second start bit begins immediately after the first stop bit. Total 320 cycles, two done pulses.
- Start while busy: assert start with in=0x3C at cycle 40 of a 0x81 frame → 0x81 is sent unaltered and 0x3C is never sent.
- Abort: drop en at cycle 70 of a frame → out=1 and busy=0 on the next edge, no done pulse. Re-enable and send 0x55 → correct frame.
- Loopback: connect out to the team's receiver `in` on the same clk, send 0x00, 0xFF, 0x5A, 0xC3 → receiver reports the matching bytes, each with done and err=0. With UART_TX_PARITY_EN defined, send 0x07 → parity bit=1, frame 176 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversample ratio and data width.
// Used by both the 8-bit receiver and the 8N1 transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_N    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Cycle counter 0..last with synchronous clear; tc is high while count == last.
// Latency: tc is combinational from the registered count; no backpressure.
module uart_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart8_transmitter.sv
// 8N1 UART transmitter: one byte per accepted start, LSB first, all outputs registered.
// Latency: out falls on the accepting edge; start is ignored while busy. Optional UART_TX_PARITY_EN adds even parity.
module uart8_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(OVERSAMPLE * STOP_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS_N - 1);

  uart_state_t   state, state_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          out_nxt, busy_nxt, done_nxt;
  logic          timer_clr, tc;
  logic [CW-1:0] tick_last;

  uart_bit_timer #(.WIDTH(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .last  (tick_last),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      out     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_idx <= bit_idx_nxt;
      out     <= out_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    out_nxt     = 1'b1;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    tick_last   = BIT_LAST;
    timer_clr   = 1'b0;

    if (!en) begin
      state_nxt   = IDLE;
      bit_idx_nxt = '0;
      busy_nxt    = 1'b0;
      timer_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          timer_clr   = 1'b1;
          busy_nxt    = 1'b0;
          bit_idx_nxt = '0;
          if (start) begin
            shift_nxt = in;
            state_nxt = START_BIT;
            out_nxt   = 1'b0;
            busy_nxt  = 1'b1;
          end
        end
        START_BIT: begin
          out_nxt = 1'b0;
          if (tc) begin
            state_nxt = DATA_BITS;
            out_nxt   = shift[0];
          end
        end
        DATA_BITS: begin
          out_nxt = shift[bit_idx];
          if (tc) begin
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_nxt = PARITY_BIT;
              out_nxt   = ^shift;
`else
              state_nxt = STOP_BIT;
              out_nxt   = 1'b1;
`endif
            end else begin
              bit_idx_nxt = bit_idx + 3'd1;
              out_nxt     = shift[bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          out_nxt = ^shift;
          if (tc) begin
            state_nxt = STOP_BIT;
            out_nxt   = 1'b1;
          end
        end
`endif
        STOP_BIT: begin
          // The stop phase spans all stop bits in one count.
          tick_last = STOP_LAST;
          if (tc) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          bit_idx_nxt = '0;
          busy_nxt    = 1'b0;
          timer_clr   = 1'b1;
        end
      endcase
    end
  end

endmodule
